// File: rtl/load_store_unit.sv
// Load/store unit: sequences PASS, word/byte loads and word/byte stores against a
// word-addressed data memory and returns one registered write-back per request.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [2:0]  ex_op,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_wdata,
    input  logic [15:0] ex_alu,
    input  logic [2:0]  ex_rd,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [2:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;
    typedef enum logic [2:0] {
        OP_PASS = 3'b000, OP_LW = 3'b001, OP_LB = 3'b010, OP_LBU = 3'b011,
        OP_SW   = 3'b100, OP_SB = 3'b101, OP_RSV6 = 3'b110, OP_RSV7 = 3'b111
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] alu_q, alu_d;
    logic [2:0]  rd_q, rd_d;
    logic [15:0] merge_q, merge_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [2:0]  wb_rd_q, wb_rd_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        mis_q, mis_d;

    logic [7:0]  byte_sel;
    logic [15:0] merged_word;

    assign byte_sel    = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign merged_word = addr_q[0] ? {wdata_q[7:0], merge_q[7:0]}
                                   : {merge_q[15:8], wdata_q[7:0]};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        alu_d      = alu_q;
        rd_d       = rd_q;
        merge_d    = merge_q;
        wb_valid_d = 1'b0;
        wb_we_d    = wb_we_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    op_d    = op_t'(ex_op);
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    alu_d   = ex_alu;
                    rd_d    = ex_rd;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr   = {1'b0, addr_q[15:1]};
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_we_d    = 1'b1;
                case (op_q)
                    OP_LW: begin
                        if (addr_q[0]) begin
                            wb_we_d   = 1'b0;
                            wb_data_d = '0;
                            mis_d     = 1'b1;
                        end else begin
                            wb_data_d = mem_rdata;
                        end
                    end
                    OP_LB:  wb_data_d = {{8{byte_sel[7]}}, byte_sel};
                    OP_LBU: wb_data_d = {8'h00, byte_sel};
                    OP_SW: begin
                        wb_we_d   = 1'b0;
                        wb_data_d = '0;
                        if (addr_q[0]) begin
                            mis_d = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_wdata = wdata_q;
                        end
                    end
                    OP_SB: begin
                        // Read half of the read-modify-write; write-back waits for MERGE.
                        wb_valid_d = 1'b0;
                        wb_we_d    = wb_we_q;
                        wb_rd_d    = wb_rd_q;
                        merge_d    = mem_rdata;
                        state_d    = MERGE;
                    end
                    default: wb_data_d = alu_q;
                endcase
            end
            MERGE: begin
                mem_addr   = {1'b0, addr_q[15:1]};
                mem_we     = 1'b1;
                mem_wdata  = merged_word;
                state_d    = IDLE;
                wb_valid_d = 1'b1;
                wb_we_d    = 1'b0;
                wb_rd_d    = rd_q;
                wb_data_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_PASS;
            addr_q     <= '0;
            wdata_q    <= '0;
            alu_q      <= '0;
            rd_q       <= '0;
            merge_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            alu_q      <= alu_d;
            rd_q       <= rd_d;
            merge_q    <= merge_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
        end
    end

    assign ex_ready     = (state_q == IDLE);
    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural model predicts each write-back
// and the memory image; a negedge monitor checks every wb_valid against the queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [15:0] ex_addr, ex_wdata, ex_alu;
    logic [2:0]  ex_rd;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        wb_valid, wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        misalign_err;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu), .ex_rd(ex_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the falling edge. Only 16 words used.
    logic [15:0] mem     [16];
    logic [15:0] ref_mem [16];
    assign mem_rdata = mem[mem_addr[3:0]];
    always @(negedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  rd;
        logic        we;
        logic [15:0] data;
        logic        chk_data;
        logic        mis;
        int unsigned due;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (misalign_err) chk("misalign_with_wb_valid", wb_valid, 1);
            if (wb_valid) begin
                chk("wb_expected_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("wb_rd", wb_rd, mon_e.rd);
                    chk("wb_we", wb_we, mon_e.we);
                    chk("misalign_err", misalign_err, mon_e.mis);
                    chk("wb_cycle", cyc, mon_e.due);
                    if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    // Issue one request; returns the number of falling edges spent waiting for ex_ready.
    task automatic issue(input logic [2:0] op, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] alu, input logic [2:0] rd, input bit hold,
                         output int unsigned waits);
        exp_t e;
        logic [15:0] b;
        int unsigned w;
        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_wdata = wdata; ex_alu = alu; ex_rd = rd;
        waits = 0;
        while (!ex_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        chk("ready_timeout", ex_ready, 1);
        w = addr[4:1];
        e.rd = rd; e.we = 1'b1; e.data = '0; e.chk_data = 1'b1; e.mis = 1'b0; e.due = cyc + 2;
        case (op)
            3'd1: begin
                if (addr[0]) begin e.mis = 1'b1; e.we = 1'b0; end
                else e.data = ref_mem[w];
            end
            3'd2, 3'd3: begin
                b = addr[0] ? (ref_mem[w] >> 8) : (ref_mem[w] & 16'h00FF);
                e.data = (op == 3'd2 && b >= 16'd128) ? b + 16'hFF00 : b;
            end
            3'd4: begin
                e.we = 1'b0;
                if (addr[0]) e.mis = 1'b1;
                else begin ref_mem[w] = wdata; e.chk_data = 1'b0; end
            end
            3'd5: begin
                e.we = 1'b0; e.chk_data = 1'b0; e.due = cyc + 3;
                ref_mem[w] = addr[0] ? ((ref_mem[w] & 16'h00FF) | {wdata[7:0], 8'h00})
                                     : ((ref_mem[w] & 16'hFF00) | {8'h00, wdata[7:0]});
            end
            default: e.data = alu;
        endcase
        if (ex_ready) q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) ex_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wt;
        logic [15:0] v;
        logic [15:0] saved;
        reset = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_wdata = '0; ex_alu = '0; ex_rd = '0;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        #12;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_release", ex_ready, 1);

        // Word store then load
        issue(3'd4, 16'h0010, 16'hBEEF, 16'h0, 3'd1, 0, wt);
        issue(3'd1, 16'h0010, 16'h0, 16'h0, 3'd3, 0, wt);
        drain();
        chk("mem8_beef", mem[8], 16'hBEEF);

        // Byte loads with sign/zero extension
        issue(3'd4, 16'h0010, 16'h80FF, 16'h0, 3'd0, 0, wt);
        issue(3'd2, 16'h0011, 16'h0, 16'h0, 3'd1, 0, wt);
        issue(3'd3, 16'h0011, 16'h0, 16'h0, 3'd2, 0, wt);
        issue(3'd2, 16'h0010, 16'h0, 16'h0, 3'd4, 0, wt);
        drain();

        // Byte store read-modify-write
        issue(3'd4, 16'h0010, 16'h1234, 16'h0, 3'd0, 0, wt);
        issue(3'd5, 16'h0011, 16'h00AB, 16'h0, 3'd5, 0, wt);
        @(negedge clk);
        chk("sb_access_no_we", mem_we, 0);
        @(negedge clk);
        chk("sb_merge_we", mem_we, 1);
        chk("sb_merge_wdata", mem_wdata, 16'hAB34);
        @(negedge clk);
        chk("mem8_ab34", mem[8], 16'hAB34);
        drain();

        // Misaligned word load
        issue(3'd1, 16'h0013, 16'h0, 16'h0, 3'd6, 0, wt);
        @(negedge clk);
        chk("mis_lw_no_we", mem_we, 0);
        chk("mis_lw_addr", mem_addr, 16'h0009);
        drain();

        // Back-to-back PASS with ex_valid held
        for (int i = 0; i < 5; i++) begin
            issue(3'd0, 16'($urandom), 16'($urandom), 16'($urandom), 3'(i), 1, wt);
            if (i > 0) chk("b2b_ready_gap", wt, 1);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        drain();

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            issue(3'($urandom_range(0, 7)), 16'($urandom_range(0, 31)), 16'($urandom),
                  16'($urandom), 3'($urandom), bit'($urandom_range(0, 1)), wt);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        drain();

        // Reset during MERGE cancels the store
        saved = mem[5];
        @(negedge clk);
        ex_valid = 1'b1; ex_op = 3'd5; ex_addr = 16'h000B; ex_wdata = ~saved; ex_rd = 3'd7;
        @(posedge clk);
        #1 ex_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_merge_mem_we", mem_we, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_merge_wb_valid", wb_valid, 0);
        @(negedge clk);
        chk("rst_merge_ready", ex_ready, 1);
        chk("rst_merge_wb_valid2", wb_valid, 0);
        chk("rst_merge_mem5", mem[5], saved);

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port ex_valid  input  1  execute stage presents a request.
REQ-004 SHALL have port ex_ready  output  1  unit accepts a request this cycle.
REQ-005 SHALL have port ex_op  input  3  000 PASS, 001 LW, 010 LB (sign-extend), 011 LBU (zero-extend), 100 SW, 101 SB; 110/111 treated as PASS.
REQ-006 SHALL have port ex_addr  input  16  byte address.
REQ-007 SHALL have port ex_wdata  input  16  store data; SB uses bits [7:0].
REQ-008 SHALL have port ex_alu  input  16  result forwarded on PASS.
REQ-009 SHALL have port ex_rd  input  3  destination register index.
REQ-010 SHALL have ports mem_we (output, 1), mem_addr (output, 16), mem_wdata (output, 16) and mem_rdata (input, 16) to the data memory: word-addressed, combinational read, write committed on the falling clock edge.
REQ-011 SHALL have ports wb_valid (output, 1), wb_we (output, 1), wb_rd (output, 3) and wb_data (output, 16) to write-back.
REQ-012 SHALL have port misalign_err  output  1  one-cycle pulse on a misaligned word access.

Function
REQ-013 SHALL implement states IDLE, ACCESS and MERGE; ex_ready = (state == IDLE).
REQ-014 SHALL, in IDLE with ex_valid high, latch op/addr/wdata/alu/rd into request registers and go to ACCESS at that rising edge; otherwise remain in IDLE.
REQ-015 SHALL drive mem_addr = {1'b0, req_addr[15:1]} in ACCESS and MERGE, and 16'h0000 in IDLE.
REQ-016 SHALL drive mem_we combinationally from state: high only in ACCESS for aligned SW, and in MERGE; never in IDLE.
REQ-017 SHALL, in ACCESS for LW, capture mem_rdata into wb_data and return to IDLE.
REQ-018 SHALL, in ACCESS for LB/LBU, select the byte (req_addr[0]=0 gives bits [7:0], 1 gives bits [15:8]; little-endian), sign- or zero-extend it to 16 bits, and return to IDLE.
REQ-019 SHALL, in ACCESS for SW, drive mem_wdata = req_wdata and return to IDLE.
REQ-020 SHALL, in ACCESS for SB, capture mem_rdata into a merge register and go to MERGE; in MERGE, drive mem_wdata = merge with the addressed byte replaced by req_wdata[7:0], then return to IDLE.
REQ-021 SHALL, in ACCESS for PASS, set wb_data = req_alu and return to IDLE with no memory activity.
REQ-022 SHALL, for LW/SW with req_addr[0]=1, perform no memory write, pulse misalign_err with wb_valid, set wb_we=0 and wb_data=16'h0000.
REQ-023 SHALL assert wb_valid for exactly one cycle, registered at the edge that leaves ACCESS (or MERGE for SB), with wb_rd = req_rd.
REQ-024 SHALL set wb_we=1 for loads and PASS, and 0 for stores and misaligned accesses.
REQ-025 SHALL give the following latency, with the request accepted at edge N: wb_valid is high in cycle N+1..N+2 for non-SB operations and in N+2..N+3 for SB.
REQ-026 SHALL sustain a throughput of at most one request per 2 cycles (3 for SB); ex_valid presented while not in IDLE is held by the producer and is not lost.
REQ-027 SHALL ignore address bits that exceed the memory depth; word address wrap-around is the memory's behaviour and is not checked.

Reset
REQ-028 SHALL, on reset high, immediately (asynchronously) enter IDLE and clear wb_valid, wb_we, wb_rd, wb_data, misalign_err, the request registers and the merge register to 0.
REQ-029 SHALL, on reset asserted during ACCESS or MERGE, drop mem_we before the next falling edge so that the in-flight store is cancelled and memory is not modified.
REQ-030 SHALL, on reset release, set ex_ready=1 at the first rising edge.

Verification
REQ-031 SHALL cover: SW addr 0x0010 data 0xBEEF, then LW 0x0010 rd=3 -> mem word 8 = 0xBEEF; wb_valid 1 cycle, wb_rd=3, wb_data=0xBEEF, wb_we=1.
REQ-032 SHALL cover: word 8 = 0x80FF; LB 0x0011 -> wb_data 0xFF80; LBU 0x0011 -> 0x0080; LB 0x0010 -> 0xFFFF.
REQ-033 SHALL cover: word 8 = 0x1234; SB 0x0011 data 0x00AB -> mem_we high only in MERGE, word 8 = 0xAB34, wb_valid at N+2 with wb_we=0.
REQ-034 SHALL cover: LW 0x0013 -> misalign_err and wb_valid high together, wb_we=0, no mem_we in any cycle.
REQ-035 SHALL cover: SB accepted, reset pulsed during MERGE before the falling edge -> memory word unchanged, wb_valid=0, state IDLE, ex_ready=1 after release.
REQ-036 SHALL cover: back-to-back PASS requests with ex_valid held high -> ex_ready toggles 1,0; each wb_data equals its ex_alu and each request is accepted exactly once.
